// File: rtl/dump_input_file.sv
// Reads the 1-bit image RAM eight entries at a time, packs each group MSB-first
// into a byte and hands it to the UART transmitter with a trmt/tx_done handshake.
module dump_input_file #(
  parameter int NUM_BITS   = 784,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  q,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [7:0]            tx_data,
  output logic                  trmt,
  input  logic                  tx_done,
  output logic                  busy,
  output logic                  done
);

  localparam int NUM_BYTES = NUM_BITS / 8;
  localparam int BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEND  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Handshake: trmt is a one-cycle strobe meaning "tx_data is valid, latch it";
  // tx_done is a one-cycle strobe from the transmitter, honoured only in S_WAIT.
  state_t                state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [6:0]            shift_q, shift_d;
  logic [7:0]            tx_data_q, tx_data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      shift_q    <= '0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      tx_data_q  <= tx_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    shift_d    = shift_q;
    tx_data_d  = tx_data_q;

    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (start) begin
          state_d    = S_FETCH;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          shift_d    = '0;
        end
      end

      // Cycle 0 presents 8k; RAM data lags one cycle, so bits land on cycles 1..8.
      S_FETCH: begin
        if (bit_cnt_q != 4'd0) begin
          shift_d = {shift_q[5:0], q};
        end
        if (bit_cnt_q == 4'd8) begin
          tx_data_d = {shift_q, q};
          bit_cnt_d = '0;
          state_d   = S_SEND;
        end else begin
          addr_d    = addr_q + 1'b1;
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end

      S_SEND: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (tx_done) begin
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = S_DONE;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            bit_cnt_d  = '0;
            state_d    = S_FETCH;
          end
        end
      end

      S_DONE: begin
        addr_d  = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
    endcase
  end

  assign addr    = addr_q;
  assign tx_data = tx_data_q;
  assign trmt    = (state_q == S_SEND);
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_dump_input_file.sv
// Bench for dump_input_file: RAM and transmitter models around the DUT, expected
// bytes queued at start and popped on every trmt.
module tb_dump_input_file;

  localparam int NB = 784;
  localparam int AW = 10;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          ram_q;
  logic [AW-1:0] addr;
  logic [7:0]    tx_data;
  logic          trmt;
  logic          tx_done;
  logic          busy;
  logic          done;

  logic          mem [0:NB-1];
  logic [7:0]    exp_q[$];
  logic          model_done;
  logic          spur_done;
  logic          tx_auto;
  int            tx_cnt;
  int            trmt_count;
  int            done_count;
  int            max_addr;
  int            cyc;
  int            done_cyc;
  int            last_txd_cyc;
  int            checks;
  int            errors;

  dump_input_file #(.NUM_BITS(NB), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .q       (ram_q),
    .addr    (addr),
    .tx_data (tx_data),
    .trmt    (trmt),
    .tx_done (tx_done),
    .busy    (busy),
    .done    (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    ram_q <= (int'(addr) < NB) ? mem[addr] : 1'b0;
  end

  assign tx_done = model_done | spur_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // transmitter model + scoreboard consumer
  always @(negedge clk) begin
    model_done = 1'b0;
    if (!rst_n) begin
      tx_cnt = 0;
    end else begin
      if (int'(addr) > max_addr) max_addr = int'(addr);
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
      if (trmt) begin
        trmt_count++;
        if (exp_q.size() == 0) begin
          check("tx_byte_unexpected", exp_q.size(), 1);
        end else begin
          check("tx_byte", tx_data, exp_q.pop_front());
        end
        if (tx_auto) tx_cnt = 20;
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          model_done = 1'b1;
          last_txd_cyc = cyc;
        end
      end
    end
  end

  // driver tasks
  task automatic load_image(input logic [7:0] first);
    logic [7:0] b;
    exp_q.delete();
    for (int k = 0; k < NB / 8; k++) begin
      b = (k == 0) ? first : 8'(k);
      for (int j = 0; j < 8; j++) mem[8*k + j] = b[7-j];
      exp_q.push_back(b);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_trmt(input int target, input string tag);
    for (int i = 0; i < 6000 && trmt_count < target; i++) begin
      @(negedge clk);
      #1;
    end
    check(tag, 32'(trmt_count >= target), 1);
  endtask

  task automatic wait_done(input int target, input string tag);
    for (int i = 0; i < 6000 && done_count < target; i++) begin
      @(negedge clk);
      #1;
    end
    check(tag, 32'(done_count >= target), 1);
  endtask

  initial begin
    int base;
    int dbase;
    int bad;
    logic [7:0] held;

    cyc = 0; checks = 0; errors = 0;
    trmt_count = 0; done_count = 0; max_addr = 0;
    done_cyc = 0; last_txd_cyc = 0; tx_cnt = 0;
    model_done = 1'b0; spur_done = 1'b0; tx_auto = 1'b1;
    start = 1'b0; rst_n = 1'b0;
    for (int i = 0; i < NB; i++) mem[i] = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_addr", addr, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_trmt", trmt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // latency and full pattern readback; first byte 10110001
    load_image(8'hB1);
    base = trmt_count;
    dbase = done_count;
    pulse_start();
    #1;
    for (int c = 0; c < 8; c++) begin
      check("lat_addr", addr, c);
      check("lat_trmt_low", trmt, 0);
      check("lat_busy", busy, 1);
      @(negedge clk);
      #1;
    end
    check("lat_addr8", addr, 8);
    check("lat_trmt_n8", trmt, 0);
    @(negedge clk);
    #1;
    check("lat_trmt_n9", trmt, 1);
    check("lat_first_byte", tx_data, 8'hB1);
    wait_done(dbase + 1, "run_a_done_timeout");
    check("run_a_trmt_count", trmt_count - base, NB / 8);
    check("run_a_queue_empty", exp_q.size(), 0);
    check("run_a_done_after_last_txd", done_cyc, last_txd_cyc + 1);
    check("max_addr", max_addr, NB);
    @(negedge clk);
    #1;
    check("run_a_busy_after", busy, 0);
    check("run_a_addr_idle", addr, 0);
    check("run_a_single_done", done_count - dbase, 1);

    // stalled transmitter
    load_image(8'h00);
    base = trmt_count;
    dbase = done_count;
    tx_auto = 1'b0;
    pulse_start();
    wait_trmt(base + 1, "stall_first_trmt_timeout");
    held = tx_data;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #1;
      if (trmt || tx_data !== held || addr !== 10'd8 || !busy) bad++;
    end
    check("stall_bad_cycles", bad, 0);
    check("stall_trmt_count", trmt_count - base, 1);
    check("stall_addr", addr, 8);
    tx_auto = 1'b1;
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    wait_done(dbase + 1, "stall_done_timeout");
    check("stall_trmt_total", trmt_count - base, NB / 8);
    check("stall_queue_empty", exp_q.size(), 0);

    // spurious start during WAIT and tx_done during FETCH
    repeat (3) @(negedge clk);
    load_image(8'h00);
    base = trmt_count;
    dbase = done_count;
    pulse_start();
    wait_trmt(base + 6, "spur_byte5_timeout");
    repeat (3) @(negedge clk);
    check("spur_in_wait_busy", busy, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_trmt(base + 10, "spur_byte9_timeout");
    bad = 1;
    for (int i = 0; i < 100 && bad == 1; i++) begin
      @(negedge clk);
      #1;
      if (model_done) bad = 0;
    end
    check("spur_txd_seen", bad, 0);
    repeat (3) @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    #1;
    check("spur_fetch_no_trmt", trmt_count - base, 10);
    wait_done(dbase + 1, "spur_done_timeout");
    check("spur_trmt_total", trmt_count - base, NB / 8);
    check("spur_queue_empty", exp_q.size(), 0);
    check("spur_single_done", done_count - dbase, 1);

    // reset during byte 40 WAIT, then restart from byte 0
    repeat (3) @(negedge clk);
    load_image(8'hB1);
    base = trmt_count;
    pulse_start();
    wait_trmt(base + 41, "rst_byte40_timeout");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_addr", addr, 0);
    check("midrst_tx_data", tx_data, 0);
    check("midrst_trmt", trmt, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    exp_q.delete();
    base = trmt_count;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("midrst_no_trmt", trmt_count - base, 0);
    check("midrst_idle_busy", busy, 0);
    load_image(8'h3C);
    dbase = done_count;
    pulse_start();
    wait_done(dbase + 1, "restart_done_timeout");
    check("restart_trmt_total", trmt_count - base, NB / 8);
    check("restart_queue_empty", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dump_input_file.md
Name: dump_input_file

Overview:
- Read-side counterpart of the image loader: reads the 1-bit-wide, 784-entry input image RAM and repacks it into bytes.
- Streams those bytes out through a byte-wide transmitter handshake (UART tx), for image readback and debug.
- Sits between the input image RAM read port and the UART transmitter.
- Bit order mirrors the loader, so a load followed by a dump reproduces the original byte stream.

Parameters:
- NUM_BITS, 784, number of 1-bit RAM entries to dump; must be a multiple of 8.
- ADDR_WIDTH, 10, RAM address width.

Ports:
- clk  input  1  system clock, 50MHz
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to begin a dump
- q  input  1  RAM read data; synchronous RAM, so q = mem[addr sampled at previous clk edge]
- addr  output  ADDR_WIDTH  RAM read address
- tx_data  output  8  byte presented to the transmitter
- trmt  output  1  one-cycle pulse: transmitter latches tx_data
- tx_done  input  1  pulse from the transmitter: byte fully sent
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse after the last byte's tx_done

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low; clk/rst_n as everywhere else.
- Reset values: addr=0, tx_data=0, trmt=0, busy=0, done=0, state=IDLE, bit/byte counters=0.
- Reset asserted mid-operation aborts the dump immediately; no further trmt is issued.
- States:
  - IDLE: addr held at 0. start=1 -> FETCH with bit_cnt=0, byte_cnt=0. tx_done ignored.
  - FETCH: assembles one byte in 9 cycles.
    - addr steps 8k, 8k+1 ... 8k+7 on consecutive cycles.
    - Shift register loads q on the 8 edges following each address presentation: shift = {shift[6:0], q}.
    - First bit read (mem[8k]) ends in tx_data[7]; mem[8k+7] ends in tx_data[0].
    - After the 8th shift: tx_data <= shift value, addr <= 8k+8, go to SEND.
  - SEND: trmt=1 for exactly this one cycle -> WAIT.
  - WAIT: tx_data held stable. tx_done=1 and byte_cnt=NUM_BITS/8-1 -> DONE. tx_done=1 otherwise -> byte_cnt+1, FETCH.
  - DONE: done=1 for one cycle, addr <= 0 -> IDLE.
- Latency: start sampled at edge N -> trmt high in the cycle after edge N+9. Each later byte follows the same 9-cycle fetch after tx_done.
- busy is 1 in FETCH, SEND, WAIT and DONE; it falls in the same cycle the state returns to IDLE.
- start while busy is ignored; no restart or queueing.
- tx_done outside WAIT is ignored.
- tx_done in the same cycle as trmt is not accepted; WAIT needs a tx_done sampled in the WAIT state.
- A full 784-bit image produces exactly 98 bytes and 98 trmt pulses; addr never exceeds 784 (0x310).
- Counters are sized to hold NUM_BITS/8 bytes. byte_cnt wraps only via IDLE.

Test Plan:
- Pattern readback: RAM loaded with bytes 0x00..0x61 MSB-first at 8k..8k+7; start; tx model returns tx_done 20 cycles after each trmt -> 98 bytes observed equal 0x00..0x61 in order; one done pulse; busy then low.
- Latency check: start at edge N -> addr=0..7 during cycles N..N+7; trmt high only in the cycle after edge N+9; first tx_data=mem[0..7] packed MSB-first (mem=10110001 -> 0xB1).
- Stalled transmitter: withhold tx_done for 500 cycles after the first trmt -> no second trmt; tx_data stays constant; addr stays 8; busy stays 1.
- Spurious inputs: start pulsed during WAIT of byte 5, and tx_done pulsed during FETCH -> byte sequence unchanged; still exactly 98 trmt pulses.
- Reset mid-dump: assert rst_n=0 during byte 40 WAIT -> all outputs 0 asynchronously; after release, a new start dumps from byte 0 again.
- Boundary: last byte (addr 776..783) -> addr never reaches 785; done one cycle after the 98th tx_done; addr=0 in the following IDLE.
